// File: rtl/dart_pkg.sv
// =====================================================================
// dart_pkg - shared widths, turn constants and FSM encoding (rev 1.0)
// =====================================================================
`default_nettype none

package dart_pkg;
    localparam int PT_W           = 9;
    localparam int SCORE_W        = 6;
    localparam int POS_W          = 8;
    localparam int DARTS_PER_TURN = 3;

    typedef enum logic [2:0] {
        WAIT_DART = 3'd0,
        LOOKUP    = 3'd1,
        UPDATE    = 3'd2,
        DONE      = 3'd3,
        TURN_END  = 3'd4,
        GAP       = 3'd5,
        GAME_SET  = 3'd6
    } state_t;
endpackage

`default_nettype wire

// File: rtl/dart_bust_check.sv
// =====================================================================
// dart_bust_check - remaining-points / bust / win rule (rev 1.0)
// Double-out rule is enabled by defining DART_DOUBLE_OUT_EN.
// =====================================================================
`default_nettype none

module dart_bust_check
    import dart_pkg::*;
(
    input  logic [PT_W-1:0]    cur_pt,
    input  logic [SCORE_W-1:0] score,
    input  logic               dbl,
    output logic [PT_W-1:0]    rem,
    output logic               bust,
    output logic               win
);
    logic [PT_W-1:0] score_ext;
    logic            over;

    assign score_ext = {{(PT_W-SCORE_W){1'b0}}, score};
    // Compare before subtracting so rem never wraps.
    assign over      = score_ext > cur_pt;
    assign rem       = over ? cur_pt : cur_pt - score_ext;

`ifdef DART_DOUBLE_OUT_EN
    assign bust = over || (rem == PT_W'(1)) || ((rem == '0) && !dbl);
`else
    logic unused_dbl;
    assign unused_dbl = dbl;
    assign bust       = over;
`endif

    assign win = !bust && (rem == '0);
endmodule

`default_nettype wire

// File: rtl/dart_game_ctrl.sv
// =====================================================================
// dart_game_ctrl - two-player dart turn sequencer and scorekeeper (rev 1.0)
// Optional double-out rule: define DART_DOUBLE_OUT_EN.
// =====================================================================
`default_nettype none

module dart_game_ctrl
    import dart_pkg::*;
#(
    parameter int START_PT = 301,
    parameter int DART_GAP = 2
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               dart_come_i,
    input  logic [POS_W-1:0]   dart_position_x_i,
    input  logic [POS_W-1:0]   dart_position_y_i,
    output logic               score_req_o,
    output logic [POS_W-1:0]   score_x_o,
    output logic [POS_W-1:0]   score_y_o,
    input  logic               score_ack_i,
    input  logic [SCORE_W-1:0] score_val_i,
    input  logic               score_dbl_i,
    output logic               player_1_done_o,
    output logic               player_2_done_o,
    output logic               player_1_win_o,
    output logic               player_2_win_o,
    output logic               game_set_o,
    output logic [PT_W-1:0]    player_1_pt_o,
    output logic [PT_W-1:0]    player_2_pt_o,
    output logic               cur_player_o,
    output logic [1:0]         dart_idx_o
);
    localparam int               GAP_W     = (DART_GAP > 1) ? $clog2(DART_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(DART_GAP - 1);
    localparam logic [PT_W-1:0]  START_VAL = PT_W'(START_PT);
    localparam logic [1:0]       LAST_IDX  = 2'(DARTS_PER_TURN - 1);

    state_t             state;
    logic [SCORE_W-1:0] score_q;
    logic               dbl_q;
    logic               bust_q;
    logic               win_q;
    logic [PT_W-1:0]    snapshot;
    logic [GAP_W-1:0]   gap_cnt;

    logic [PT_W-1:0]    cur_pt;
    logic [PT_W-1:0]    rem;
    logic [PT_W-1:0]    upd_pt;
    logic               bust;
    logic               win;

    assign cur_pt = cur_player_o ? player_2_pt_o : player_1_pt_o;
    assign upd_pt = bust ? snapshot : rem;

    dart_bust_check u_bust_check (
        .cur_pt (cur_pt),
        .score  (score_q),
        .dbl    (dbl_q),
        .rem    (rem),
        .bust   (bust),
        .win    (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= WAIT_DART;
            score_req_o     <= 1'b0;
            score_x_o       <= '0;
            score_y_o       <= '0;
            score_q         <= '0;
            dbl_q           <= 1'b0;
            bust_q          <= 1'b0;
            win_q           <= 1'b0;
            snapshot        <= START_VAL;
            gap_cnt         <= '0;
            player_1_done_o <= 1'b0;
            player_2_done_o <= 1'b0;
            player_1_win_o  <= 1'b0;
            player_2_win_o  <= 1'b0;
            game_set_o      <= 1'b0;
            player_1_pt_o   <= START_VAL;
            player_2_pt_o   <= START_VAL;
            cur_player_o    <= 1'b0;
            dart_idx_o      <= '0;
        end else begin
            player_1_done_o <= 1'b0;
            player_2_done_o <= 1'b0;
            case (state)
                WAIT_DART: begin
                    if (dart_come_i) begin
                        score_x_o   <= dart_position_x_i;
                        score_y_o   <= dart_position_y_i;
                        score_req_o <= 1'b1;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (score_ack_i) begin
                        score_q     <= score_val_i;
                        dbl_q       <= score_dbl_i;
                        score_req_o <= 1'b0;
                        state       <= UPDATE;
                    end
                end
                UPDATE: begin
                    // Points and the done pulse move together on this edge.
                    bust_q <= bust;
                    win_q  <= win;
                    if (cur_player_o) begin
                        player_2_pt_o   <= upd_pt;
                        player_2_done_o <= 1'b1;
                    end else begin
                        player_1_pt_o   <= upd_pt;
                        player_1_done_o <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (win_q) begin
                        game_set_o <= 1'b1;
                        if (cur_player_o) player_2_win_o <= 1'b1;
                        else              player_1_win_o <= 1'b1;
                        state <= GAME_SET;
                    end else if (bust_q || (dart_idx_o == LAST_IDX)) begin
                        state <= TURN_END;
                    end else begin
                        dart_idx_o <= dart_idx_o + 2'd1;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end
                end
                TURN_END: begin
                    cur_player_o <= ~cur_player_o;
                    dart_idx_o   <= '0;
                    snapshot     <= cur_player_o ? player_1_pt_o : player_2_pt_o;
                    gap_cnt      <= '0;
                    state        <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= WAIT_DART;
                    else                     gap_cnt <= gap_cnt + GAP_W'(1);
                end
                GAME_SET: state <= GAME_SET;
                default:  state <= WAIT_DART;
            endcase
        end
    end
endmodule

`default_nettype wire
